// File: rtl/imm_gen_pkg.sv
// Immediate generator: shared format codes and opcodes.
// Used by the decoder and the pipeline top.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  function automatic logic uses_target(fmt_e f);
    return (f == FMT_B) || (f == FMT_J);
  endfunction

endpackage

// File: rtl/imm_gen_if.sv
// Immediate generator: instruction in / result out handshake bundle.
// master drives instructions and consumes results; slave is the block.
interface imm_gen_if #(
  parameter int XLEN = 32
);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            flush_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] imm_o;
  logic [2:0]      fmt_o;
  logic [XLEN-1:0] target_o;
  logic            illegal_o;

  modport master (
    output in_valid_i, instr_i, pc_i,
    output flush_i, out_ready_i,
    input  in_ready_o, out_valid_o,
    input  imm_o, fmt_o, target_o, illegal_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i,
    input  flush_i, out_ready_i,
    output in_ready_o, out_valid_o,
    output imm_o, fmt_o, target_o, illegal_o
  );
endinterface

// File: rtl/imm_gen_pipe_imm_decode.sv
// Immediate decoder: opcode -> format, sign-extended immediate.
// Purely combinational.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  opc;
  logic [31:0] imm32;
  logic        is_r, is_i, is_s;
  logic        is_b, is_u, is_j;

  assign opc  = instr[6:0];
  assign is_r = (opc == OPC_OP) ||
                (RV64_OPS && opc == OPC_OP_32);
  assign is_i = (opc == OPC_OP_IMM) ||
                (opc == OPC_LOAD) ||
                (opc == OPC_JALR) ||
                (opc == OPC_SYSTEM) ||
                (RV64_OPS && opc == OPC_OP_IMM_32);
  assign is_s = (opc == OPC_STORE);
  assign is_b = (opc == OPC_BRANCH);
  assign is_u = (opc == OPC_LUI) || (opc == OPC_AUIPC);
  assign is_j = (opc == OPC_JAL);

  always_comb begin
    fmt     = FMT_ILL;
    illegal = 1'b0;
    imm32   = '0;
    unique case (1'b1)
      is_r: fmt = FMT_R;
      is_i: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      is_s: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25],
                 instr[11:7]};
      end
      is_b: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
      end
      is_u: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      is_j: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator pipe: decode + target add into a 2-entry skid FIFO.
// in_ready_o depends on registered state only.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit RV64_OPS = 1'b0
) (
  input logic        clk_i,
  input logic        rst_i,
  imm_gen_if.slave   bus
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_ill;
  logic [XLEN-1:0] dec_tgt;

  imm_decode #(
    .XLEN     (XLEN),
    .RV64_OPS (RV64_OPS)
  ) u_dec (
    .instr   (bus.instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign dec_tgt = uses_target(dec_fmt) ?
                   bus.pc_i + dec_imm : bus.pc_i;

  logic [XLEN-1:0] imm_q [2];
  logic [XLEN-1:0] tgt_q [2];
  fmt_e            fmt_q [2];
  logic            ill_q [2];
  logic [1:0]      count;
  logic            wr_ptr, rd_ptr;
  logic            rdy_q;
  logic            out_v, push, pop;

  // rdy_q keeps in_ready_o low until the first edge after reset.
  assign out_v          = (count != 2'd0);
  assign bus.in_ready_o = rdy_q && (count != 2'd2);
  assign bus.out_valid_o = out_v;

  assign push = bus.in_valid_i && bus.in_ready_o &&
                !bus.flush_i;
  assign pop  = out_v && bus.out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      rdy_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        tgt_q[i] <= '0;
        fmt_q[i] <= FMT_R;
        ill_q[i] <= 1'b0;
      end
    end else begin
      rdy_q <= 1'b1;
      if (bus.flush_i) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) begin
          imm_q[wr_ptr] <= dec_imm;
          tgt_q[wr_ptr] <= dec_tgt;
          fmt_q[wr_ptr] <= dec_fmt;
          ill_q[wr_ptr] <= dec_ill;
          wr_ptr        <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        if (push && !pop)
          count <= count + 2'd1;
        else if (pop && !push)
          count <= count - 2'd1;
      end
    end
  end

  assign bus.imm_o     = out_v ? imm_q[rd_ptr] : '0;
  assign bus.target_o  = out_v ? tgt_q[rd_ptr] : '0;
  assign bus.fmt_o     = out_v ? fmt_q[rd_ptr] : FMT_R;
  assign bus.illegal_o = out_v ? ill_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe (XLEN=32 plain, XLEN=64 with RV64 ops).
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_imm_gen_pipe;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  imm_gen_if #(.XLEN(32)) b32 ();
  imm_gen_if #(.XLEN(64)) b64 ();

  imm_gen_pipe #(.XLEN(32), .RV64_OPS(1'b0)) dut32 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b32.slave)
  );

  imm_gen_pipe #(.XLEN(64), .RV64_OPS(1'b1)) dut64 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins,
                       input logic [31:0] pc);
    b32.in_valid_i = 1'b1;
    b32.instr_i    = ins;
    b32.pc_i       = pc;
  endtask

  task automatic idle;
    b32.in_valid_i = 1'b0;
    b32.instr_i    = '0;
  endtask

  task automatic test_reset;
    #2;
    n_chk++;
    if (b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_valid: got %b want 0", b32.out_valid_o);
    end
    n_chk++;
    if (b32.imm_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_imm: got %h want 0", b32.imm_o);
    end
    n_chk++;
    if (b32.fmt_o !== 3'd0) begin
      n_err++;
      $display("FAIL rst_fmt: got %0d want 0", b32.fmt_o);
    end
    n_chk++;
    if (b32.target_o !== 32'h0) begin
      n_err++;
      $display("FAIL rst_target: got %h want 0", b32.target_o);
    end
    n_chk++;
    if (b32.illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL rst_illegal: got %b want 0", b32.illegal_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_chk++;
    if (b32.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_ready: got %b want 1", b32.in_ready_o);
    end
  endtask

  task automatic test_store;
    n_chk++;
    if (b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL sw_pre_valid: got %b want 0", b32.out_valid_o);
    end
    drive(32'hFE512E23, 32'h40);
    tick();
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL sw_valid: got %b want 1", b32.out_valid_o);
    end
    n_chk++;
    if (b32.imm_o !== 32'hFFFFFFFC) begin
      n_err++;
      $display("FAIL sw_imm: got %h want FFFFFFFC", b32.imm_o);
    end
    n_chk++;
    if (b32.fmt_o !== 3'd2) begin
      n_err++;
      $display("FAIL sw_fmt: got %0d want 2", b32.fmt_o);
    end
    n_chk++;
    if (b32.target_o !== 32'h40) begin
      n_err++;
      $display("FAIL sw_target: got %h want 40", b32.target_o);
    end
    tick();
    n_chk++;
    if (b32.out_valid_o !== 1'b0 || b32.imm_o !== 32'h0) begin
      n_err++;
      $display("FAIL sw_drain: got v=%b imm=%h want v=0 imm=0",
               b32.out_valid_o, b32.imm_o);
    end
  endtask

  task automatic test_branch;
    drive(32'hFE000CE3, 32'h100);
    tick();
    idle();
    n_chk++;
    if (b32.imm_o !== 32'hFFFFFFF8) begin
      n_err++;
      $display("FAIL beq_imm: got %h want FFFFFFF8", b32.imm_o);
    end
    n_chk++;
    if (b32.fmt_o !== 3'd3) begin
      n_err++;
      $display("FAIL beq_fmt: got %0d want 3", b32.fmt_o);
    end
    n_chk++;
    if (b32.target_o !== 32'hF8) begin
      n_err++;
      $display("FAIL beq_target: got %h want F8", b32.target_o);
    end
    tick();
  endtask

  task automatic test_formats;
    logic [31:0] v_ins [6];
    logic [31:0] v_pc  [6];
    logic [31:0] v_imm [6];
    logic [2:0]  v_fmt [6];
    logic [31:0] v_tgt [6];
    logic        v_ill [6];
    v_ins[0] = 32'h123450B7; v_pc[0] = 32'h200;
    v_imm[0] = 32'h12345000; v_fmt[0] = 3'd4;
    v_tgt[0] = 32'h200;      v_ill[0] = 1'b0;
    v_ins[1] = 32'hFFF00093; v_pc[1] = 32'h10;
    v_imm[1] = 32'hFFFFFFFF; v_fmt[1] = 3'd1;
    v_tgt[1] = 32'h10;       v_ill[1] = 1'b0;
    v_ins[2] = 32'h0000007F; v_pc[2] = 32'h20;
    v_imm[2] = 32'h0;        v_fmt[2] = 3'd7;
    v_tgt[2] = 32'h20;       v_ill[2] = 1'b1;
    v_ins[3] = 32'h008000EF; v_pc[3] = 32'hFFFFFFFC;
    v_imm[3] = 32'h8;        v_fmt[3] = 3'd5;
    v_tgt[3] = 32'h4;        v_ill[3] = 1'b0;
    v_ins[4] = 32'h00B50533; v_pc[4] = 32'h30;
    v_imm[4] = 32'h0;        v_fmt[4] = 3'd0;
    v_tgt[4] = 32'h30;       v_ill[4] = 1'b0;
    v_ins[5] = 32'h0015051B; v_pc[5] = 32'h34;
    v_imm[5] = 32'h0;        v_fmt[5] = 3'd7;
    v_tgt[5] = 32'h34;       v_ill[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(v_ins[i], v_pc[i]);
      tick();
      idle();
      n_chk++;
      if (b32.imm_o !== v_imm[i]) begin
        n_err++;
        $display("FAIL fmt%0d_imm: got %h want %h",
                 i, b32.imm_o, v_imm[i]);
      end
      n_chk++;
      if (b32.fmt_o !== v_fmt[i]) begin
        n_err++;
        $display("FAIL fmt%0d_fmt: got %0d want %0d",
                 i, b32.fmt_o, v_fmt[i]);
      end
      n_chk++;
      if (b32.target_o !== v_tgt[i]) begin
        n_err++;
        $display("FAIL fmt%0d_target: got %h want %h",
                 i, b32.target_o, v_tgt[i]);
      end
      n_chk++;
      if (b32.illegal_o !== v_ill[i]) begin
        n_err++;
        $display("FAIL fmt%0d_illegal: got %b want %b",
                 i, b32.illegal_o, v_ill[i]);
      end
      tick();
    end
  endtask

  task automatic test_xlen64;
    b64.in_valid_i = 1'b1;
    b64.instr_i    = 32'hFFF00093;
    b64.pc_i       = 64'h1000;
    tick();
    n_chk++;
    if (b64.imm_o !== 64'hFFFFFFFFFFFFFFFF) begin
      n_err++;
      $display("FAIL x64_addi_imm: got %h want all ones", b64.imm_o);
    end
    b64.instr_i = 32'h0015051B;
    tick();
    n_chk++;
    if (b64.imm_o !== 64'h1 || b64.fmt_o !== 3'd1 ||
        b64.illegal_o !== 1'b0) begin
      n_err++;
      $display("FAIL x64_addiw: got imm=%h fmt=%0d ill=%b want 1/1/0",
               b64.imm_o, b64.fmt_o, b64.illegal_o);
    end
    b64.instr_i = 32'hFE000CE3;
    b64.pc_i    = 64'h0;
    tick();
    b64.in_valid_i = 1'b0;
    n_chk++;
    if (b64.target_o !== 64'hFFFFFFFFFFFFFFF8) begin
      n_err++;
      $display("FAIL x64_beq_wrap: got %h want FFFFFFFFFFFFFFF8",
               b64.target_o);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    b32.out_ready_i = 1'b0;
    drive(32'h00100093, 32'h0);
    tick();
    drive(32'h00200093, 32'h4);
    tick();
    drive(32'h00300093, 32'h8);
    n_chk++;
    if (b32.in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_full_ready: got %b want 0", b32.in_ready_o);
    end
    tick();
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h1) begin
      n_err++;
      $display("FAIL b2b_head: got v=%b imm=%h want v=1 imm=1",
               b32.out_valid_o, b32.imm_o);
    end
    tick();
    n_chk++;
    if (b32.imm_o !== 32'h1 || b32.target_o !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_stable: got imm=%h tgt=%h want 1/0",
               b32.imm_o, b32.target_o);
    end
    b32.out_ready_i = 1'b1;
    tick();
    n_chk++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h2 ||
        b32.target_o !== 32'h4) begin
      n_err++;
      $display("FAIL b2b_second: got v=%b imm=%h tgt=%h want 1/2/4",
               b32.out_valid_o, b32.imm_o, b32.target_o);
    end
    tick();
    n_chk++;
    if (b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_third: got %b want 0", b32.out_valid_o);
    end
  endtask

  task automatic test_push_pop;
    b32.out_ready_i = 1'b1;
    drive(32'h00500093, 32'h0);
    tick();
    n_chk++;
    if (b32.imm_o !== 32'h5) begin
      n_err++;
      $display("FAIL pp_first: got %h want 5", b32.imm_o);
    end
    drive(32'h00600093, 32'h0);
    tick();
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h6 ||
        b32.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL pp_second: got v=%b imm=%h rdy=%b want 1/6/1",
               b32.out_valid_o, b32.imm_o, b32.in_ready_o);
    end
    tick();
    n_chk++;
    if (b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL pp_empty: got %b want 0", b32.out_valid_o);
    end
  endtask

  task automatic test_flush;
    b32.out_ready_i = 1'b0;
    drive(32'h00100093, 32'h0);
    tick();
    drive(32'h00200093, 32'h0);
    tick();
    drive(32'h00700093, 32'h0);
    b32.flush_i = 1'b1;
    tick();
    b32.flush_i = 1'b0;
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b0 || b32.in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL flush_state: got v=%b rdy=%b want 0/1",
               b32.out_valid_o, b32.in_ready_o);
    end
    b32.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (b32.out_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL flush_leak%0d: got v=%b imm=%h want v=0",
                 i, b32.out_valid_o, b32.imm_o);
      end
    end
    drive(32'h00800093, 32'h0);
    tick();
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b1 || b32.imm_o !== 32'h8) begin
      n_err++;
      $display("FAIL flush_recover: got v=%b imm=%h want 1/8",
               b32.out_valid_o, b32.imm_o);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    b32.out_ready_i = 1'b0;
    drive(32'hFFF00093, 32'h0);
    tick();
    drive(32'h123450B7, 32'h0);
    tick();
    idle();
    n_chk++;
    if (b32.out_valid_o !== 1'b1 || b32.in_ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL rm_full: got v=%b rdy=%b want 1/0",
               b32.out_valid_o, b32.in_ready_o);
    end
    #3 rst_n = 1'b0;
    #1;
    n_chk++;
    if (b32.out_valid_o !== 1'b0 || b32.imm_o !== 32'h0 ||
        b32.fmt_o !== 3'd0 || b32.target_o !== 32'h0) begin
      n_err++;
      $display("FAIL rm_async: got v=%b imm=%h fmt=%0d want 0/0/0",
               b32.out_valid_o, b32.imm_o, b32.fmt_o);
    end
    #2 rst_n = 1'b1;
    tick();
    n_chk++;
    if (b32.in_ready_o !== 1'b1 || b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rm_release: got rdy=%b v=%b want 1/0",
               b32.in_ready_o, b32.out_valid_o);
    end
    b32.out_ready_i = 1'b1;
    tick();
    n_chk++;
    if (b32.out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rm_no_stale: got %b want 0", b32.out_valid_o);
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    b32.in_valid_i  = 1'b0;
    b32.instr_i     = '0;
    b32.pc_i        = '0;
    b32.flush_i     = 1'b0;
    b32.out_ready_i = 1'b1;
    b64.in_valid_i  = 1'b0;
    b64.instr_i     = '0;
    b64.pc_i        = '0;
    b64.flush_i     = 1'b0;
    b64.out_ready_i = 1'b1;
    test_reset();
    test_store();
    test_branch();
    test_formats();
    test_xlen64();
    test_back_to_back();
    test_push_pop();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RV64_OPS, default 0; when 1 (XLEN=64 only), decodes OP-IMM-32/OP-32 opcodes.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid_i  input  1  instruction offered.
REQ-006 SHALL have port in_ready_o  output  1  block can accept an instruction.
REQ-007 SHALL have port instr_i  input  32  raw instruction.
REQ-008 SHALL have port pc_i  input  XLEN  PC of instr_i.
REQ-009 SHALL have port flush_i  input  1  discard all held and incoming entries.
REQ-010 SHALL have port out_valid_o  output  1  result available.
REQ-011 SHALL have port out_ready_i  input  1  consumer takes result.
REQ-012 SHALL have port imm_o  output  XLEN  sign-extended immediate.
REQ-013 SHALL have port fmt_o  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-014 SHALL have port target_o  output  XLEN  pc+imm for B/J; pc otherwise.
REQ-015 SHALL have port illegal_o  output  1  opcode not decodable.

Function
REQ-016 SHALL decode format from instr[6:0]: 0110011 R; 0010011/0000011/1100111/1110011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; with RV64_OPS=1, 0011011 I and 0111011 R; else ILL with illegal_o=1.
REQ-017 SHALL form immediates: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; U={instr[31:12],12'b0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; each sign-extended from its MSB (instr[31]) to XLEN; R and ILL give 0.
REQ-018 SHALL compute target_o as pc_i+imm modulo 2^XLEN, wrap-around silent, at capture time.
REQ-019 SHALL register results in a 2-entry FIFO (skid buffer), in-order; latency one cycle from accept to out_valid_o when empty.
REQ-020 SHALL accept an instruction on a cycle with in_valid_i=1 and in_ready_o=1; SHALL pop on out_valid_o=1 and out_ready_i=1.
REQ-021 SHALL drive in_ready_o from registered state only: 1 when fewer than 2 entries held (no combinational path from out_ready_i).
REQ-022 SHALL handle simultaneous push and pop when holding 1 entry: count stays 1, new entry presented next cycle.
REQ-023 SHALL present head entry stably while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL on flush_i=1 empty the FIFO at the next edge, ignore any push in that cycle, and hold in_ready_o=1 the following cycle; flush overrides push and pop.
REQ-025 SHALL keep outputs at 0 whenever out_valid_o=0.

Reset
REQ-026 SHALL on rst_i=0 asynchronously clear count and pointers, out_valid_o=0, imm_o=0, fmt_o=0, target_o=0, illegal_o=0; in_ready_o=1 from the first edge after release.
REQ-027 SHALL drop all in-flight entries on reset asserted mid-operation; no partial entry emitted after release.

Structure
REQ-028 SHALL place format codes and opcode constants in shared package imm_gen_pkg.
REQ-029 SHALL use one combinational sub-module imm_decode (instr, XLEN -> imm, fmt, illegal); FIFO and adder in imm_gen_pipe.

Verification
REQ-030 SHALL test: instr 0xFE512E23 (sw x5,-4(x2)), XLEN=32 -> imm 0xFFFFFFFC, fmt 2, one cycle later.
REQ-031 SHALL test: instr 0xFE000CE3 (beq -8), pc 0x100 -> imm 0xFFFFFFF8, fmt 3, target 0xF8.
REQ-032 SHALL test: 0x123450B7 -> imm 0x12345000 fmt 4; 0xFFF00093 -> 0xFFFFFFFF fmt 1; XLEN=64 -> 0xFFFFFFFFFFFFFFFF; opcode 0x7F -> illegal_o=1, fmt 7.
REQ-033 SHALL test: out_ready_i=0, three back-to-back pushes -> two accepted, in_ready_o=0 on third; release -> outputs in push order, no loss or duplicate.
REQ-034 SHALL test: FIFO full, flush_i with in_valid_i=1 -> out_valid_o=0 next cycle, pushed instr never emitted.
REQ-035 SHALL test: rst_i low mid-stream with 2 held -> outputs 0 immediately, in_ready_o=1 after release.
